// File: rtl/native2protocol_arb.sv
// native2protocol_arb
// Per-channel FIFOs collect words from the DLA native channels. A single
// round-robin arbiter loads one word at a time into a valid/ready output
// register that feeds the protocol layer.
module native2protocol_arb #(
    parameter int N_CH       = 4,
    parameter int DLA_DATA_W = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int ALLOC_THR  = 2
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       enable,
    input  logic [N_CH*DLA_DATA_W-1:0]                 dla_data_i,
    input  logic [N_CH-1:0]                            dla_valid_i,
    output logic [N_CH-1:0]                            dla_ready_o,
    output logic [N_CH-1:0]                            dla_allocatable_o,
    output logic [DLA_DATA_W-1:0]                      proto_data_o,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] proto_ch_o,
    output logic                                       proto_valid_o,
    input  logic                                       proto_ready_i,
    output logic                                       busy_o
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CH_W-1:0] LAST_INIT = CH_W'(N_CH - 1);

    // Storage is deliberately not reset: reset only clears the pointers,
    // which is enough to make every pre-reset word unreachable.
    logic [DLA_DATA_W-1:0] r_mem  [N_CH][FIFO_DEPTH];
    logic [PTR_W:0]        r_wptr [N_CH];
    logic [PTR_W:0]        r_rptr [N_CH];
    logic [PTR_W:0]        w_cnt  [N_CH];
    logic [CH_W-1:0]       r_last;
    logic                  r_live;

    logic [N_CH-1:0]       w_full;
    logic [N_CH-1:0]       w_empty;
    logic [N_CH-1:0]       w_push;
    logic [N_CH-1:0]       w_pop;
    logic [CH_W-1:0]       w_sel;
    logic                  w_found;
    logic                  w_load;

    // Out-of-reset flag: keeps ready low while rst_n is asserted, using registered state only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Per-channel FIFO status, ready/allocatable flags and push qualification.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_full[c]  = (r_wptr[c][PTR_W] != r_rptr[c][PTR_W]) &&
                         (r_wptr[c][PTR_W-1:0] == r_rptr[c][PTR_W-1:0]);
            w_empty[c] = (r_wptr[c] == r_rptr[c]);
            w_cnt[c]   = r_wptr[c] - r_rptr[c];
            dla_ready_o[c]       = r_live & enable & ~w_full[c];
            dla_allocatable_o[c] = ((FIFO_DEPTH - int'(w_cnt[c])) >= ALLOC_THR);
            w_push[c]  = dla_valid_i[c] & dla_ready_o[c];
        end
    end

    // Round-robin search starting one past the last granted channel; decides the output load.
    always_comb begin
        int idx;
        w_sel   = '0;
        w_found = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(r_last) + 1 + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end else begin
                idx = idx;
            end
            if (!w_found && !w_empty[idx]) begin
                w_found = 1'b1;
                w_sel   = CH_W'(idx);
            end else begin
                w_found = w_found;
            end
        end
        w_load = (~proto_valid_o | proto_ready_i) & enable & w_found;
        for (int c = 0; c < N_CH; c++) begin
            w_pop[c] = w_load && (int'(w_sel) == c);
        end
    end

    // FIFO pointer advance on push and pop; push and pop may happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_push[c]) begin
                    r_wptr[c] <= r_wptr[c] + PTR_ONE;
                end
                if (w_pop[c]) begin
                    r_rptr[c] <= r_rptr[c] + PTR_ONE;
                end
            end
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (w_push[c]) begin
                r_mem[c][r_wptr[c][PTR_W-1:0]] <= dla_data_i[c*DLA_DATA_W +: DLA_DATA_W];
            end
        end
    end

    // Output register: reload on a free or draining slot, hold while stalled, clear after a plain handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_data_o  <= '0;
            proto_ch_o    <= '0;
            proto_valid_o <= 1'b0;
            r_last        <= LAST_INIT;
        end else if (w_load) begin
            proto_data_o  <= r_mem[w_sel][r_rptr[w_sel][PTR_W-1:0]];
            proto_ch_o    <= w_sel;
            proto_valid_o <= 1'b1;
            r_last        <= w_sel;
        end else if (proto_valid_o && proto_ready_i) begin
            proto_valid_o <= 1'b0;
        end
    end

    assign busy_o = (|(~w_empty)) | proto_valid_o;

endmodule

// File: tb/tb_native2protocol_arb.sv
// Self-checking bench for native2protocol_arb: directed corner sequences,
// a table-driven fill test and randomized traffic against a queue model.
module tb_native2protocol_arb;

    localparam int NC    = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int THR   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NC*DW-1:0]  dla_data_i;
    logic [NC-1:0]     dla_valid_i;
    logic [NC-1:0]     dla_ready_o;
    logic [NC-1:0]     dla_allocatable_o;
    logic [DW-1:0]     proto_data_o;
    logic [1:0]        proto_ch_o;
    logic              proto_valid_o;
    logic              proto_ready_i;
    logic              busy_o;

    always #5 clk = ~clk;

    native2protocol_arb #(
        .N_CH(NC), .DLA_DATA_W(DW), .FIFO_DEPTH(DEPTH), .ALLOC_THR(THR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .dla_data_i(dla_data_i), .dla_valid_i(dla_valid_i),
        .dla_ready_o(dla_ready_o), .dla_allocatable_o(dla_allocatable_o),
        .proto_data_o(proto_data_o), .proto_ch_o(proto_ch_o),
        .proto_valid_o(proto_valid_o), .proto_ready_i(proto_ready_i),
        .busy_o(busy_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per channel, an output slot and the last grant.
    logic [DW-1:0] mq [NC][$];
    bit            mv;
    logic [DW-1:0] md;
    int            mch;
    int            mlast;

    typedef struct {
        logic [DW-1:0] wdata;
        logic          exp_rdy0;
        logic          exp_alloc0;
    } fill_vec_t;

    fill_vec_t fill_tab [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_init();
        for (int c = 0; c < NC; c++) mq[c].delete();
        mv    = 1'b0;
        md    = '0;
        mch   = 0;
        mlast = NC - 1;
    endtask

    task automatic check_all();
        logic [NC-1:0] er;
        logic [NC-1:0] ea;
        bit            any;
        any = 1'b0;
        for (int c = 0; c < NC; c++) begin
            er[c] = enable && (mq[c].size() < DEPTH);
            ea[c] = ((DEPTH - mq[c].size()) >= THR);
            if (mq[c].size() > 0) any = 1'b1;
        end
        chk("dla_ready", 64'(dla_ready_o), 64'(er));
        chk("dla_allocatable", 64'(dla_allocatable_o), 64'(ea));
        chk("busy", 64'(busy_o), 64'(any || mv));
        chk("proto_valid", 64'(proto_valid_o), 64'(mv));
        if (mv) begin
            chk("proto_data", proto_data_o, md);
            chk("proto_ch", 64'(proto_ch_o), 64'(mch));
        end
    endtask

    // Advance the model by one clock edge using the pre-edge state.
    task automatic model_step(input logic en, input logic [NC-1:0] v,
                              input logic [NC*DW-1:0] d, input logic pr);
        bit [NC-1:0] rdy;
        bit          any;
        bit          done;
        any = 1'b0;
        for (int c = 0; c < NC; c++) begin
            rdy[c] = en && (mq[c].size() < DEPTH);
            if (mq[c].size() > 0) any = 1'b1;
        end
        if ((!mv || pr) && en && any) begin
            done = 1'b0;
            for (int i = 1; i <= NC; i++) begin
                int c;
                c = (mlast + i) % NC;
                if (!done && mq[c].size() > 0) begin
                    md    = mq[c].pop_front();
                    mch   = c;
                    mv    = 1'b1;
                    mlast = c;
                    done  = 1'b1;
                end
            end
        end else if (mv && pr) begin
            mv = 1'b0;
        end
        for (int c = 0; c < NC; c++) begin
            if (v[c] && rdy[c]) mq[c].push_back(d[c*DW +: DW]);
        end
    endtask

    // Called at a falling edge: drive, compare, then move through one rising edge.
    task automatic step(input logic en, input logic [NC-1:0] v,
                        input logic [NC*DW-1:0] d, input logic pr);
        enable        = en;
        dla_valid_i   = v;
        dla_data_i    = d;
        proto_ready_i = pr;
        #1;
        check_all();
        model_step(en, v, d, pr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        enable        = 1'b1;
        dla_valid_i   = '0;
        dla_data_i    = '0;
        proto_ready_i = 1'b0;
        #1;
        chk("rst_ready", 64'(dla_ready_o), 64'(0));
        chk("rst_alloc", 64'(dla_allocatable_o), 64'(4'hF));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_valid", 64'(proto_valid_o), 64'(0));
        chk("rst_data", proto_data_o, 64'(0));
        chk("rst_ch", 64'(proto_ch_o), 64'(0));
        model_init();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [NC*DW-1:0] rnd_data();
        logic [NC*DW-1:0] r;
        for (int c = 0; c < NC; c++) r[c*DW +: DW] = {$urandom, $urandom};
        return r;
    endfunction

    initial begin
        logic [NC*DW-1:0] d;
        logic [DW-1:0]    wa;
        logic [DW-1:0]    wb;
        int               rr_exp [8];

        rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
        fill_tab[0] = '{64'h11, 1'b1, 1'b1};
        fill_tab[1] = '{64'h12, 1'b1, 1'b1};
        fill_tab[2] = '{64'h13, 1'b1, 1'b1};
        fill_tab[3] = '{64'h14, 1'b1, 1'b1};
        fill_tab[4] = '{64'h15, 1'b1, 1'b1};
        fill_tab[5] = '{64'h16, 1'b1, 1'b1};
        fill_tab[6] = '{64'h17, 1'b1, 1'b0};
        fill_tab[7] = '{64'h18, 1'b0, 1'b0};
        fill_tab[8] = '{64'h19, 1'b0, 1'b0};

        do_reset();

        // Single word on channel 2: visible after the second edge, then gone.
        d = '0;
        d[2*DW +: DW] = 64'hA5;
        step(1'b1, 4'b0100, d, 1'b1);
        chk("lat_not_yet", 64'(proto_valid_o), 64'(0));
        step(1'b1, 4'b0000, '0, 1'b1);
        chk("lat_valid", 64'(proto_valid_o), 64'(1));
        chk("lat_data", proto_data_o, 64'hA5);
        chk("lat_ch", 64'(proto_ch_o), 64'(2));
        step(1'b1, 4'b0000, '0, 1'b1);
        chk("lat_clear", 64'(proto_valid_o), 64'(0));

        // Fill channel 0 while the output slot is stalled on a channel 1 word.
        do_reset();
        d = '0;
        d[1*DW +: DW] = 64'hBEEF;
        step(1'b1, 4'b0010, d, 1'b0);
        step(1'b1, 4'b0000, '0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            d = '0;
            d[DW-1:0] = fill_tab[i].wdata;
            step(1'b1, 4'b0001, d, 1'b0);
            chk("fill_ready0", 64'(dla_ready_o[0]), 64'(fill_tab[i].exp_rdy0));
            chk("fill_alloc0", 64'(dla_allocatable_o[0]), 64'(fill_tab[i].exp_alloc0));
        end
        for (int i = 0; i < 12; i++) step(1'b1, 4'b0000, '0, 1'b1);

        // Two words per channel drain strictly round-robin.
        do_reset();
        step(1'b1, 4'b1111, rnd_data(), 1'b0);
        step(1'b1, 4'b1111, rnd_data(), 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("rr_valid", 64'(proto_valid_o), 64'(1));
            chk("rr_ch", 64'(proto_ch_o), 64'(rr_exp[i]));
            step(1'b1, 4'b0000, '0, 1'b1);
        end
        chk("rr_done", 64'(proto_valid_o), 64'(0));

        // Stall for five cycles, then a single ready pulse.
        do_reset();
        wa = 64'h0123_4567_89AB_CDEF;
        wb = 64'hFEDC_BA98_7654_3210;
        d = '0;
        d[3*DW +: DW] = wa;
        step(1'b1, 4'b1000, d, 1'b0);
        d[3*DW +: DW] = wb;
        step(1'b1, 4'b1000, d, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(proto_valid_o), 64'(1));
            chk("hold_data", proto_data_o, wa);
            chk("hold_ch", 64'(proto_ch_o), 64'(3));
            step(i[0] ? 1'b0 : 1'b1, 4'b0000, '0, 1'b0);
        end
        step(1'b1, 4'b0000, '0, 1'b1);
        chk("pulse_valid", 64'(proto_valid_o), 64'(1));
        chk("pulse_data", proto_data_o, wb);
        step(1'b1, 4'b0000, '0, 1'b1);

        // Enable dropped with three words in flight on channel 1.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = '0;
            d[1*DW +: DW] = 64'(32'hC000 + i);
            step(1'b1, 4'b0010, d, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0010, rnd_data(), 1'b1);
        chk("en0_noload", 64'(proto_valid_o), 64'(0));
        chk("en0_busy", 64'(busy_o), 64'(1));
        step(1'b1, 4'b0000, '0, 1'b1);
        chk("en1_w1", proto_data_o, 64'hC001);
        step(1'b1, 4'b0000, '0, 1'b1);
        chk("en1_w2", proto_data_o, 64'hC002);
        step(1'b1, 4'b0000, '0, 1'b1);

        // Randomized traffic with phases of heavy and light back-pressure.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int pr_pct;
            pr_pct = ((i / 100) % 2 == 0) ? 80 : 25;
            step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                 4'($urandom),
                 rnd_data(),
                 ($urandom_range(0, 99) < pr_pct) ? 1'b1 : 1'b0);
        end

        // Reset mid-operation with five words buffered.
        do_reset();
        step(1'b1, 4'b1111, rnd_data(), 1'b0);
        step(1'b1, 4'b0001, rnd_data(), 1'b0);
        chk("pre_rst_busy", 64'(busy_o), 64'(1));
        #2;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b0000, '0, 1'b1);
            chk("post_rst_valid", 64'(proto_valid_o), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
